// File: rtl/row_frame_tx.sv
// row_frame_tx: captures rows into a two-bank ping-pong buffer and streams each as header/data/trailer.
// Optional macro ROW_CHECKSUM_EN inserts a mod-2^16 data checksum word before the trailer.
module row_frame_tx #(
    parameter int         ROW_LEN = 48,
    parameter int         AW      = 6,
    parameter logic [3:0] HDR_TAG = 4'hA,
    parameter logic [3:0] TRL_TAG = 4'hD
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ENABLE,
    input  logic          FIRST_ROW_FLAG,
    input  logic [15:0]   DATA_IN,
    input  logic [AW-1:0] ADDR_IN,
    input  logic          WREN_IN,
    output logic [15:0]   TX_DATA,
    output logic          TX_VALID,
    output logic          TX_LAST,
    input  logic          TX_READY,
    output logic          ARMED,
    output logic          BUSY,
    output logic [15:0]   DROP_CNT
);

    localparam logic [AW:0]   ROW_LEN_W = (AW+1)'(ROW_LEN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROW_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
`ifdef ROW_CHECKSUM_EN
        S_CSUM,
`endif
        S_TRL
    } rd_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0]   mem [0:(2**(AW+1))-1];
    logic [11:0]   bank_seq [0:1];

    logic          armed;
    logic          capturing;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    bank_full;
    logic [1:0]    bank_full_nxt;
    logic [11:0]   seq;
    logic [15:0]   drop_cnt;

    logic          row_start;
    logic          wr_empty;
    logic          row_write;
    logic          mem_we;
    logic          row_done;
    logic          release_bank;

    rd_state_t     state;
    rd_state_t     state_nxt;
    logic [15:0]   tx_data_nxt;
    logic          tx_valid_nxt;
    logic          tx_last_nxt;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_nxt;
    logic [AW-1:0] data_idx;
    logic [AW-1:0] data_idx_nxt;
    logic          pf_load;
    logic [15:0]   rd_word_p0;
    logic          accept;
`ifdef ROW_CHECKSUM_EN
    logic [15:0]   csum;
    logic [15:0]   csum_nxt;
`endif

    // Capture side: a bank being released on this edge is treated as already empty
    always_comb begin
        row_start = WREN_IN && (ADDR_IN == '0) && armed && ENABLE;
        wr_empty  = !bank_full[wr_bank] || (release_bank && (rd_bank == wr_bank));
        row_write = WREN_IN && capturing && !row_start && ({1'b0, ADDR_IN} < ROW_LEN_W);
        mem_we    = (row_start && wr_empty) || row_write;
        row_done  = row_write && (ADDR_IN == LAST_ADDR);

        bank_full_nxt = bank_full;
        if (release_bank) bank_full_nxt[rd_bank] = 1'b0;
        if (row_done)     bank_full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            armed     <= 1'b0;
            capturing <= 1'b0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
            seq       <= '0;
            drop_cnt  <= '0;
        end else begin
            if (FIRST_ROW_FLAG) armed <= 1'b1;
            bank_full <= bank_full_nxt;
            if (release_bank) rd_bank <= ~rd_bank;
            if (row_start) begin
                seq       <= seq + 12'd1;
                capturing <= wr_empty;
                if (!wr_empty) drop_cnt <= sat_inc16(drop_cnt);
            end else if (row_done) begin
                capturing <= 1'b0;
                wr_bank   <= ~wr_bank;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[{wr_bank, ADDR_IN}] <= DATA_IN;
        if (row_start && wr_empty) bank_seq[wr_bank] <= seq;
        if (pf_load) rd_word_p0 <= mem[{rd_bank, rd_addr}];
`ifdef ROW_CHECKSUM_EN
        csum <= csum_nxt;
`endif
    end

    // Read side: rd_word_p0 always holds the word after the one on TX_DATA, so accepts never stall
    assign accept = TX_VALID && TX_READY;

    always_comb begin
        state_nxt    = state;
        tx_data_nxt  = TX_DATA;
        tx_valid_nxt = TX_VALID;
        tx_last_nxt  = TX_LAST;
        rd_addr_nxt  = rd_addr;
        data_idx_nxt = data_idx;
        pf_load      = 1'b0;
        release_bank = 1'b0;
`ifdef ROW_CHECKSUM_EN
        csum_nxt     = csum;
`endif
        case (state)
            S_IDLE: begin
                pf_load = 1'b1;
                if (bank_full[rd_bank]) begin
                    state_nxt    = S_HDR;
                    tx_data_nxt  = {HDR_TAG, bank_seq[rd_bank]};
                    tx_valid_nxt = 1'b1;
                    tx_last_nxt  = 1'b0;
                    rd_addr_nxt  = AW'(1);
                    data_idx_nxt = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_nxt   = S_DATA;
                    tx_data_nxt = rd_word_p0;
                    pf_load     = 1'b1;
                    rd_addr_nxt = rd_addr + AW'(1);
`ifdef ROW_CHECKSUM_EN
                    csum_nxt    = rd_word_p0;
`endif
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (data_idx == LAST_ADDR) begin
`ifdef ROW_CHECKSUM_EN
                        state_nxt   = S_CSUM;
                        tx_data_nxt = csum;
`else
                        state_nxt   = S_TRL;
                        tx_data_nxt = {TRL_TAG, bank_seq[rd_bank]};
                        tx_last_nxt = 1'b1;
`endif
                    end else begin
                        tx_data_nxt  = rd_word_p0;
                        pf_load      = 1'b1;
                        rd_addr_nxt  = rd_addr + AW'(1);
                        data_idx_nxt = data_idx + AW'(1);
`ifdef ROW_CHECKSUM_EN
                        csum_nxt     = csum + rd_word_p0;
`endif
                    end
                end
            end
`ifdef ROW_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_nxt   = S_TRL;
                    tx_data_nxt = {TRL_TAG, bank_seq[rd_bank]};
                    tx_last_nxt = 1'b1;
                end
            end
`endif
            S_TRL: begin
                if (accept) begin
                    state_nxt    = S_IDLE;
                    tx_valid_nxt = 1'b0;
                    tx_last_nxt  = 1'b0;
                    release_bank = 1'b1;
                    rd_addr_nxt  = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            TX_LAST  <= 1'b0;
            rd_addr  <= '0;
            data_idx <= '0;
        end else begin
            state    <= state_nxt;
            TX_DATA  <= tx_data_nxt;
            TX_VALID <= tx_valid_nxt;
            TX_LAST  <= tx_last_nxt;
            rd_addr  <= rd_addr_nxt;
            data_idx <= data_idx_nxt;
        end
    end

    assign ARMED    = armed;
    assign BUSY     = (state != S_IDLE);
    assign DROP_CNT = drop_cnt;

endmodule

// File: tb/tb_row_frame_tx.sv
// Directed bench for row_frame_tx: framing, stalls, drops, aborts, reset and checksum word.
module tb_row_frame_tx;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE;
    logic        FIRST_ROW_FLAG;
    logic [15:0] DATA_IN;
    logic [5:0]  ADDR_IN;
    logic        WREN_IN;
    logic [15:0] TX_DATA;
    logic        TX_VALID;
    logic        TX_LAST;
    logic        TX_READY;
    logic        ARMED;
    logic        BUSY;
    logic [15:0] DROP_CNT;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] rxq[$];
    logic        rxl[$];
    logic [15:0] expq[$];
    logic [15:0] exp_csum;
    int          rx_gap;
    int          rx_hold_err;
    bit          rx_timeout;

    row_frame_tx dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FIRST_ROW_FLAG(FIRST_ROW_FLAG),
        .DATA_IN(DATA_IN), .ADDR_IN(ADDR_IN), .WREN_IN(WREN_IN),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_LAST(TX_LAST), .TX_READY(TX_READY),
        .ARMED(ARMED), .BUSY(BUSY), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic write_row(input logic [15:0] base, input logic [15:0] step,
                             input int last, input int stray_at);
        for (int a = 0; a <= last; a++) begin
            if (a == stray_at) begin
                WREN_IN = 1'b1; ADDR_IN = 6'd50; DATA_IN = 16'hBEEF;
                @(negedge CLK);
            end
            WREN_IN = 1'b1;
            ADDR_IN = 6'(a);
            DATA_IN = base + step * 16'(a);
            @(negedge CLK);
        end
        WREN_IN = 1'b0;
    endtask

    task automatic build_exp(input logic [11:0] sq, input logic [15:0] base, input logic [15:0] step);
        logic [15:0] sum;
        logic [15:0] w;
        sum = 16'd0;
        expq.delete();
        expq.push_back({4'hA, sq});
        for (int a = 0; a < 48; a++) begin
            w = base + step * 16'(a);
            expq.push_back(w);
            sum = sum + w;
        end
        exp_csum = sum;
`ifdef ROW_CHECKSUM_EN
        expq.push_back(exp_csum);
`endif
        expq.push_back({4'hD, sq});
    endtask

    // Called on a negedge; drives TX_READY and records accepted words until TX_LAST.
    task automatic rx_frame(input bit toggle, input int budget);
        int          cyc = 0;
        bit          rdy = 1'b1;
        bit          done = 1'b0;
        bit          started = 1'b0;
        bit          pstall = 1'b0;
        logic [15:0] pd = '0;
        logic        pl = 1'b0;
        rxq.delete(); rxl.delete();
        rx_gap = 0; rx_hold_err = 0;
        while (!done && cyc < budget) begin
            TX_READY = rdy;
            if (pstall && (TX_VALID !== 1'b1 || TX_DATA !== pd || TX_LAST !== pl)) rx_hold_err++;
            pstall = 1'b0;
            if (TX_VALID === 1'b1 && rdy) begin
                started = 1'b1;
                rxq.push_back(TX_DATA);
                rxl.push_back(TX_LAST);
                if (TX_LAST === 1'b1) done = 1'b1;
            end else if (TX_VALID === 1'b1) begin
                pstall = 1'b1; pd = TX_DATA; pl = TX_LAST;
            end else if (started && rdy) begin
                rx_gap++;
            end
            if (toggle) rdy = !rdy;
            @(negedge CLK);
            cyc++;
        end
        TX_READY = 1'b0;
        rx_timeout = !done;
    endtask

    task automatic check_frame(input string tag);
        check({tag, ".timeout"}, 32'(rx_timeout), 32'd0);
        check({tag, ".len"}, 32'(rxq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
            check($sformatf("%s.w%0d", tag, i), 32'(rxq[i]), 32'(expq[i]));
            check($sformatf("%s.last%0d", tag, i), 32'(rxl[i]), 32'(i == expq.size() - 1));
        end
    endtask

    task automatic arm();
        FIRST_ROW_FLAG = 1'b1;
        @(negedge CLK);
        FIRST_ROW_FLAG = 1'b0;
    endtask

    initial begin
        RST = 1'b1; ENABLE = 1'b0; FIRST_ROW_FLAG = 1'b0;
        DATA_IN = '0; ADDR_IN = '0; WREN_IN = 1'b0; TX_READY = 1'b0;
        repeat (2) @(negedge CLK);

        // reset values
        check("rst.valid", 32'(TX_VALID), 32'd0);
        check("rst.last",  32'(TX_LAST),  32'd0);
        check("rst.data",  32'(TX_DATA),  32'd0);
        check("rst.armed", 32'(ARMED),    32'd0);
        check("rst.busy",  32'(BUSY),     32'd0);
        check("rst.drop",  32'(DROP_CNT), 32'd0);
        RST = 1'b0; ENABLE = 1'b1;
        @(negedge CLK);
        arm();
        check("t1.armed", 32'(ARMED), 32'd1);

        // single row, header one cycle after the bank-full edge, streamed back-to-back
        write_row(16'h1000, 16'd1, 47, -1);
        check("t1.valid_at_k", 32'(TX_VALID), 32'd0);
        @(negedge CLK);
        check("t1.valid_k1", 32'(TX_VALID), 32'd1);
        check("t1.hdr_k1",   32'(TX_DATA),  32'hA000);
        check("t1.busy",     32'(BUSY),     32'd1);
        build_exp(12'd0, 16'h1000, 16'd1);
        rx_frame(1'b0, 200);
        check_frame("t1");
        check("t1.gaps", 32'(rx_gap), 32'd0);
        check("t1.idle", 32'(BUSY), 32'd0);

        // same row with TX_READY toggling
        write_row(16'h1000, 16'd1, 47, -1);
        build_exp(12'd1, 16'h1000, 16'd1);
        rx_frame(1'b1, 300);
        check_frame("t2");
        check("t2.hold", 32'(rx_hold_err), 32'd0);

        // both banks occupied: third row dropped, seq gap visible
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        arm();
        write_row(16'h2000, 16'd1, 47, -1);
        write_row(16'h2100, 16'd1, 47, -1);
        write_row(16'h2200, 16'd1, 47, -1);
        check("t3.drop", 32'(DROP_CNT), 32'd1);
        check("t3.hold_valid", 32'(TX_VALID), 32'd1);
        check("t3.hold_hdr", 32'(TX_DATA), 32'hA000);
        build_exp(12'd0, 16'h2000, 16'd1);
        rx_frame(1'b0, 200);
        check_frame("t3a");
        build_exp(12'd1, 16'h2100, 16'd1);
        rx_frame(1'b0, 200);
        check_frame("t3b");
        write_row(16'h2300, 16'd1, 47, -1);
        build_exp(12'd3, 16'h2300, 16'd1);
        rx_frame(1'b0, 200);
        check_frame("t3c");

        // partial row discarded by a new row start
        write_row(16'h3000, 16'd1, 20, -1);
        write_row(16'h4000, 16'd1, 47, -1);
        build_exp(12'd5, 16'h4000, 16'd1);
        rx_frame(1'b0, 200);
        check_frame("t4");
        repeat (5) @(negedge CLK);
        check("t4.no_second", 32'(TX_VALID), 32'd0);
        check("t4.drop", 32'(DROP_CNT), 32'd1);

        // reset in the middle of a frame
        write_row(16'h5000, 16'd1, 47, -1);
        @(negedge CLK);
        TX_READY = 1'b1;
        repeat (10) @(negedge CLK);
        check("t5.mid_busy", 32'(BUSY), 32'd1);
        check("t5.mid_data", 32'(TX_DATA), 32'h5009);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("t5.valid", 32'(TX_VALID), 32'd0);
        check("t5.armed", 32'(ARMED),    32'd0);
        check("t5.drop",  32'(DROP_CNT), 32'd0);
        check("t5.busy",  32'(BUSY),     32'd0);
        write_row(16'h5500, 16'd1, 47, -1);
        repeat (5) @(negedge CLK);
        check("t5.unarmed_valid", 32'(TX_VALID), 32'd0);
        check("t5.unarmed_busy",  32'(BUSY),     32'd0);
        TX_READY = 1'b0;
        arm();
        write_row(16'h6000, 16'd1, 47, -1);
        build_exp(12'd0, 16'h6000, 16'd1);
        rx_frame(1'b0, 200);
        check_frame("t5");

        // constant-ones row with an out-of-range write in the middle
        write_row(16'h0001, 16'd0, 47, 10);
        build_exp(12'd1, 16'h0001, 16'd0);
        check("t6.model_sum", 32'(exp_csum), 32'h0030);
        rx_frame(1'b0, 200);
        check_frame("t6");
        check("t6.gaps", 32'(rx_gap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
